// File: rtl/dataflow_chan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dataflow_chan_pkg
// Brief    : Shared types and helpers for dataflow channel FIFOs and detectors.
// Revision : 1.0
// ============================================================================
package dataflow_chan_pkg;

    localparam int STALL_W_DEFAULT = 16;

    // Blocking/occupancy view of one channel as sampled by the deadlock detector.
    typedef struct packed {
        logic full_n;
        logic empty_n;
        logic wr_blk_n;
        logic rd_blk_n;
    } chan_status_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dataflow_chan_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : dataflow_chan_fifo_mem
// Brief    : DEPTH x DATA_W register array, one write port, async read port.
// Revision : 1.0
// ============================================================================
module dataflow_chan_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dataflow_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dataflow_chan_fifo
// Brief    : First-word fall-through channel FIFO with blocking flags and
//            saturating stall counters for deadlock monitoring.
// Revision : 1.0
// ============================================================================
module dataflow_chan_fifo
    import dataflow_chan_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int STALL_W = STALL_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic [DATA_W-1:0]     if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_W-1:0]     if_dout,
    output logic                  if_empty_n,
    output logic [clog2(DEPTH):0] occupancy,
    output logic                  wr_blk_n,
    output logic                  rd_blk_n,
    input  logic                  clr_stats,
    output logic [STALL_W-1:0]    wr_stall_cnt,
    output logic [STALL_W-1:0]    rd_stall_cnt
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] c_full_occ = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] c_one_occ  = OCC_W'(1);

    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [OCC_W-1:0]   r_occ;
    logic               r_full_n;
    logic               r_empty_n;
    logic               r_wr_blk_n;
    logic               r_rd_blk_n;
    logic [DATA_W-1:0]  r_dout;
    logic [STALL_W-1:0] r_wr_stall;
    logic [STALL_W-1:0] r_rd_stall;

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_wr_stall;
    logic               w_rd_stall;
    logic [PTR_W-1:0]   w_wptr_inc;
    logic [PTR_W-1:0]   w_rptr_inc;
    logic [OCC_W-1:0]   w_occ_next;
    logic [DATA_W-1:0]  w_mem_rdata;

    assign w_wr_acc   = if_write & r_full_n;
    assign w_rd_acc   = if_read & r_empty_n;
    assign w_wr_stall = if_write & ~r_full_n;
    assign w_rd_stall = if_read & ~r_empty_n;

    assign w_wptr_inc = (r_wptr == c_last_ptr) ? '0 : r_wptr + PTR_W'(1);
    assign w_rptr_inc = (r_rptr == c_last_ptr) ? '0 : r_rptr + PTR_W'(1);

    always_comb begin
        w_occ_next = r_occ;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_occ_next = r_occ + c_one_occ;
            2'b01:   w_occ_next = r_occ - c_one_occ;
            default: w_occ_next = r_occ;
        endcase
    end

    dataflow_chan_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (if_din),
        .i_raddr (w_rptr_inc),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_full_n   <= 1'b1;
            r_empty_n  <= 1'b0;
            r_wr_blk_n <= 1'b1;
            r_rd_blk_n <= 1'b1;
            r_dout     <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_rd_acc) begin
                r_rptr <= w_rptr_inc;
            end
            r_occ      <= w_occ_next;
            r_full_n   <= (w_occ_next != c_full_occ);
            r_empty_n  <= (w_occ_next != '0);
            r_wr_blk_n <= ~w_wr_stall;
            r_rd_blk_n <= ~w_rd_stall;
            // Head register: a write into an empty FIFO, or a pop with one entry
            // left while writing, takes if_din because it is not in the array yet.
            if (w_wr_acc && !r_empty_n) begin
                r_dout <= if_din;
            end else if (w_rd_acc && (w_occ_next != '0)) begin
                r_dout <= (w_wr_acc && (r_occ == c_one_occ)) ? if_din : w_mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_stall <= '0;
            r_rd_stall <= '0;
        end else if (clr_stats) begin
            r_wr_stall <= '0;
            r_rd_stall <= '0;
        end else begin
            if (w_wr_stall && (r_wr_stall != '1)) begin
                r_wr_stall <= r_wr_stall + STALL_W'(1);
            end
            if (w_rd_stall && (r_rd_stall != '1)) begin
                r_rd_stall <= r_rd_stall + STALL_W'(1);
            end
        end
    end

    assign if_full_n    = r_full_n;
    assign if_empty_n   = r_empty_n;
    assign if_dout      = r_dout;
    assign occupancy    = r_occ;
    assign wr_blk_n     = r_wr_blk_n;
    assign rd_blk_n     = r_rd_blk_n;
    assign wr_stall_cnt = r_wr_stall;
    assign rd_stall_cnt = r_rd_stall;

endmodule
`default_nettype wire

// File: doc/dataflow_chan_fifo.md
# dataflow_chan_fifo

Parameterized dataflow channel FIFO. It sits between two dataflow processes and drives the `full_n`/`empty_n` and blocking status signals that the deadlock detection logic samples. It is the producer side of that monitoring interface: it generates the blocking and occupancy information the detector consumes. It also keeps saturating stall statistics for co-simulation debug.

## Interface
Parameters:
- DATA_W, 32, payload width in bits
- DEPTH, 4, number of entries; minimum 2; need not be a power of two
- STALL_W, 16, width of each stall counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- if_write  in  1  producer write request
- if_din  in  DATA_W  write data
- if_full_n  out  1  high when an entry is free
- if_read  in  1  consumer read request
- if_dout  out  DATA_W  head entry (first-word fall-through)
- if_empty_n  out  1  high when `if_dout` holds valid data
- occupancy  out  clog2(DEPTH)+1  entries currently stored
- wr_blk_n  out  1  registered; low in the cycle after a write was attempted while full
- rd_blk_n  out  1  registered; low in the cycle after a read was attempted while empty
- clr_stats  in  1  synchronous clear of both stall counters
- wr_stall_cnt  out  STALL_W  cycles with `if_write & ~if_full_n`, saturating
- rd_stall_cnt  out  STALL_W  cycles with `if_read & ~if_empty_n`, saturating

## Operation
- A write is accepted when `if_write & if_full_n` at the clock edge. `if_din` is stored at the write pointer, and the write pointer advances.
- A read is accepted when `if_read & if_empty_n` at the clock edge. The read pointer advances, and `if_dout` shows the next entry or holds its last value if the FIFO becomes empty.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. Explicit compare, no power-of-two masking.
- Occupancy update: +1 on write only, -1 on read only, unchanged on both or neither.
- `if_full_n` = (occupancy != DEPTH). `if_empty_n` = (occupancy != 0). Both are registered, derived from next-state occupancy.
- Simultaneous write and read:
  - When full: the read is accepted and the write is rejected, because `if_full_n` is low in that cycle. The FIFO is not-full next cycle.
  - When empty: the write is accepted and the read is ignored. There is no bypass; the data appears the next cycle.
  - Otherwise: both are accepted and occupancy is unchanged.
- Stall counters:
  - Each increments by 1 per qualifying cycle and saturates at 2^STALL_W-1.
  - `clr_stats` forces both to 0 and has priority over increment.
- `wr_blk_n`/`rd_blk_n` are registered copies of `~(if_write & ~if_full_n)` and `~(if_read & ~if_empty_n)`.
- Storage contents are not reset. Only pointers, flags, counters and `if_dout` are reset.

## Timing
- Reset values (asynchronous, immediate on `reset` low):
  - `if_full_n`=1, `if_empty_n`=0, `occupancy`=0, `if_dout`=0
  - `wr_blk_n`=1, `rd_blk_n`=1, both stall counters 0
- Write-to-read latency: a write accepted at edge N raises `if_empty_n`, with valid `if_dout`, after edge N; the data is readable at edge N+1.
- Read-to-space latency: a read from a full FIFO at edge N raises `if_full_n` after edge N.
- Full throughput: one write and one read per cycle in steady state. No bubble at DEPTH ≥ 2.
- Reset asserted mid-operation: all stored entries are discarded, flags return to reset values, and no partial write is observed after release.
- Inputs are sampled on the rising edge only. Requests while blocked have no side effect beyond the stall counters and blocking flags.

## Structure
- Shared package `dataflow_chan_pkg`:
  - `clog2` function
  - `chan_status_t` struct {full_n, empty_n, wr_blk_n, rd_blk_n}, for detector-side wiring
  - `STALL_W_DEFAULT` constant
- Sub-module `dataflow_chan_fifo_mem`: simple dual-port register array, one write port and one asynchronous read port, DEPTH × DATA_W, no reset.
- The top level holds the pointers, occupancy, flag registers, output register and stall counters.

## Test plan
- Reset, then write 0xA1, 0xB2, 0xC3 on consecutive cycles with DEPTH=4 -> `occupancy` 3, `if_full_n`=1, `if_dout`=0xA1; three reads return A1, B2, C3; then `if_empty_n`=0.
- Fill to DEPTH=4, then hold `if_write` high for 5 cycles -> `if_full_n`=0, FIFO contents unchanged, `wr_stall_cnt`=5, `wr_blk_n` low from the cycle after the first stalled edge.
- Full FIFO with `if_write` and `if_read` both high for one edge -> head popped, write rejected, `occupancy` 3, `if_full_n`=1.
- DEPTH=3, stream 10 words with continuous write and read -> in-order output across pointer wrap, no gaps after the first word, `occupancy` never exceeds 1.
- `reset` dropped with 2 entries stored, released 3 cycles later -> `if_empty_n`=0 and `occupancy`=0; the next written word 0x55 is the first one read.
- STALL_W=4, read an empty FIFO for 20 cycles, then pulse `clr_stats` -> `rd_stall_cnt` saturates at 15, then reads 0.
